// File: rtl/delta_liafn_pkg.sv
// delta_liafn_pkg: shared types and constants for the delta-LIAFN scheduler.
//   state_t - scheduler FSM states (IDLE/RUN/EMIT/DONE)
//   U_W     - membrane / current / magnitude width
//   IDX_W   - neuron index width
//   DEF_*   - default leak factor (Q0.8), spike threshold, delta threshold
package delta_liafn_pkg;

    localparam int U_W          = 8;
    localparam int IDX_W        = 4;
    localparam int DEF_BETA     = 128;
    localparam int DEF_V_TH     = 200;
    localparam int DEF_DELTA_TH = 50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/delta_liafn_sched_core.sv
// lif_update_core: combinational leaky-integrate-and-fire update for one neuron.
//   u_old  in   membrane state before the update
//   cur    in   input current
//   u_new  out  membrane state after leak, integrate, saturate and fire/reset
//   mag    out  |u_new - u_old|
//   spike  out  neuron fired (saturated sum >= V_TH)
//   ev_hit out  update is significant: spike, or mag >= DELTA_TH
module lif_update_core
    import delta_liafn_pkg::*;
#(
    parameter int BETA     = DEF_BETA,
    parameter int V_TH     = DEF_V_TH,
    parameter int DELTA_TH = DEF_DELTA_TH
) (
    input  logic [U_W-1:0] u_old,
    input  logic [U_W-1:0] cur,
    output logic [U_W-1:0] u_new,
    output logic [U_W-1:0] mag,
    output logic           spike,
    output logic           ev_hit
);

    logic [15:0]       prod;
    logic [U_W-1:0]    leak;
    logic [U_W:0]      sum;
    logic [U_W-1:0]    sat;
    logic signed [U_W:0] diff;

    always_comb begin
        prod   = 16'(u_old) * 16'(BETA);
        leak   = U_W'(prod >> 8);
        sum    = {1'b0, leak} + {1'b0, cur};
        sat    = sum[U_W] ? '1 : sum[U_W-1:0];
        spike  = (sat >= U_W'(V_TH));
        u_new  = spike ? '0 : sat;
        diff   = $signed({1'b0, u_new}) - $signed({1'b0, u_old});
        // |diff| always fits in U_W bits since both operands are unsigned U_W
        mag    = diff[U_W] ? U_W'(-diff) : diff[U_W-1:0];
        ev_hit = spike | (mag >= U_W'(DELTA_TH));
    end

endmodule

// File: rtl/delta_liafn_sched.sv
// delta_liafn_sched: time-multiplexed LIF scheduler. On each tick sweeps all
// neurons in index order through one lif_update_core and emits one event per
// significant membrane change on a valid/ready stream.
//   clk, rst_n                   clock, asynchronous active-low reset
//   cur_we/cur_addr/cur_wdata    current register-file write (addr >= NUM_NEURONS ignored)
//   tick                         start a sweep (only honoured in IDLE)
//   ev_valid/ev_ready            event stream handshake
//   ev_addr/ev_mag/ev_spike      event payload, held stable while ev_valid
//   busy                         sweep in progress
//   done                         1-cycle pulse at end of sweep
//   u_mon                        membrane state of neuron 0
//   ovr_cnt                      saturating dropped-tick count (only with
//                                DELTA_LIAFN_OVERRUN_CNT_EN defined)
module delta_liafn_sched
    import delta_liafn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int BETA        = DEF_BETA,
    parameter int V_TH        = DEF_V_TH,
    parameter int DELTA_TH    = DEF_DELTA_TH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [U_W-1:0]   cur_wdata,
    input  logic             tick,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_addr,
    output logic [U_W-1:0]   ev_mag,
    output logic             ev_spike,
    output logic             busy,
    output logic             done,
    output logic [U_W-1:0]   u_mon
`ifdef DELTA_LIAFN_OVERRUN_CNT_EN
    ,
    output logic [7:0]       ovr_cnt
`endif
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [U_W-1:0]   u_q   [NUM_NEURONS];
    logic [U_W-1:0]   cur_q [NUM_NEURONS];
    logic [U_W-1:0]   u_sel, cur_sel, u_new, mag;
    logic             spike, ev_hit, last;

    assign last  = (idx == IDX_W'(NUM_NEURONS - 1));
    assign u_mon = u_q[0];

    // Read mux for the neuron under update
    always_comb begin
        u_sel   = '0;
        cur_sel = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx == IDX_W'(i)) begin
                u_sel   = u_q[i];
                cur_sel = cur_q[i];
            end
        end
    end

    lif_update_core #(
        .BETA     (BETA),
        .V_TH     (V_TH),
        .DELTA_TH (DELTA_TH)
    ) u_core (
        .u_old  (u_sel),
        .cur    (cur_sel),
        .u_new  (u_new),
        .mag    (mag),
        .spike  (spike),
        .ev_hit (ev_hit)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (tick) state_nxt = ST_RUN;
            ST_RUN: begin
                if (ev_hit)    state_nxt = ST_EMIT;
                else if (last) state_nxt = ST_DONE;
            end
            ST_EMIT: if (ev_ready) state_nxt = last ? ST_DONE : ST_RUN;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        ev_valid = (state == ST_EMIT);
    end

    // Index advances after a quiet neuron or after its event is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (state == ST_IDLE && tick) begin
            idx <= '0;
        end else if ((state == ST_RUN && !ev_hit && !last) ||
                     (state == ST_EMIT && ev_ready && !last)) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_addr  <= '0;
            ev_mag   <= '0;
            ev_spike <= 1'b0;
        end else if (state == ST_RUN && ev_hit) begin
            ev_addr  <= idx;
            ev_mag   <= mag;
            ev_spike <= spike;
        end
    end

    // Membrane and current register files. A current write to the neuron in
    // RUN lands at the same edge that consumes the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                u_q[i]   <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (state == ST_RUN && idx == IDX_W'(i)) u_q[i]   <= u_new;
                if (cur_we && cur_addr == IDX_W'(i))     cur_q[i] <= cur_wdata;
            end
        end
    end

`ifdef DELTA_LIAFN_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       ovr_cnt <= '0;
        else if (tick && state != ST_IDLE && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_delta_liafn_sched.sv
module tb_delta_liafn_sched;

    localparam int N     = 4;
    localparam int BETA  = 128;
    localparam int V_TH  = 200;
    localparam int D_TH  = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cur_we = 1'b0;
    logic [3:0] cur_addr = '0;
    logic [7:0] cur_wdata = '0;
    logic       tick = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_spike, busy, done;
    logic [3:0] ev_addr;
    logic [7:0] ev_mag, u_mon;
`ifdef DELTA_LIAFN_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt;
`endif

    always #5 clk = ~clk;

    delta_liafn_sched #(.NUM_NEURONS(N), .BETA(BETA), .V_TH(V_TH), .DELTA_TH(D_TH)) dut (
        .clk(clk), .rst_n(rst_n), .cur_we(cur_we), .cur_addr(cur_addr), .cur_wdata(cur_wdata),
        .tick(tick), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr),
        .ev_mag(ev_mag), .ev_spike(ev_spike), .busy(busy), .done(done), .u_mon(u_mon)
`ifdef DELTA_LIAFN_OVERRUN_CNT_EN
        , .ovr_cnt(ovr_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {int addr; int mag; int spike;} ev_s;
    ev_s exp_q[$];
    int  u_m[N];
    int  cur_m[N];
    int  ovr_m = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: one full sweep computed straight from the LIF rules
    task automatic model_sweep();
        for (int i = 0; i < N; i++) begin
            int leak, sum, un, mg, sp;
            leak = (u_m[i] * BETA) / 256;
            sum  = leak + cur_m[i];
            if (sum > 255) sum = 255;
            sp   = (sum >= V_TH) ? 1 : 0;
            un   = sp ? 0 : sum;
            mg   = (un > u_m[i]) ? un - u_m[i] : u_m[i] - un;
            if (sp == 1 || mg >= D_TH) exp_q.push_back('{i, mg, sp});
            u_m[i] = un;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            u_m[i] = 0;
            cur_m[i] = 0;
        end
        ovr_m = 0;
        exp_q.delete();
    endtask

    // Event compare: pops the scoreboard on every handshake, checks payload stability under stall
    logic       hold_v = 1'b0;
    logic [3:0] h_a;
    logic [7:0] h_m;
    logic       h_s;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", int'(ev_valid), 1);
                check("hold_addr", int'(ev_addr), int'(h_a));
                check("hold_mag", int'(ev_mag), int'(h_m));
                check("hold_spike", int'(ev_spike), int'(h_s));
            end
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    ev_s e;
                    e = exp_q.pop_front();
                    check("ev_addr", int'(ev_addr), e.addr);
                    check("ev_mag", int'(ev_mag), e.mag);
                    check("ev_spike", int'(ev_spike), e.spike);
                end
                hold_v = 1'b0;
            end else if (ev_valid) begin
                hold_v = 1'b1;
                h_a = ev_addr;
                h_m = ev_mag;
                h_s = ev_spike;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic wr_cur(input int a, input int d);
        cur_we    = 1'b1;
        cur_addr  = 4'(a);
        cur_wdata = 8'(d);
        @(posedge clk); #1;
        cur_we = 1'b0;
        if (a < N) cur_m[a] = d;
    endtask

    // Runs one sweep whose expected events are already queued.
    // bp_pct: percent of cycles with ev_ready low; tick_pct: percent of cycles
    // with a (to-be-dropped) tick; stall: cycles of forced ev_ready low in EMIT.
    task automatic do_sweep(input int bp_pct, input int tick_pct, input int stall, output int lat);
        int nev, st;
        nev = exp_q.size();
        st  = stall;
        ev_ready = 1'b1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        lat  = 1;
        while (!done && lat < 2000) begin
            check("busy_in_sweep", int'(busy), 1);
            ev_ready = (bp_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= bp_pct);
            if (st > 0 && ev_valid) begin
                ev_ready = 1'b0;
                st--;
            end
            if ($urandom_range(0, 99) < tick_pct) begin
                tick = 1'b1;
                if (ovr_m < 255) ovr_m++;
            end
            @(posedge clk); #1;
            tick = 1'b0;
            lat++;
        end
        ev_ready = 1'b1;
        check("done_seen", int'(done), 1);
        if (bp_pct == 0 && stall == 0) check("latency", lat, N + 1 + nev);
        check("events_left", exp_q.size(), 0);
        exp_q.delete();
        check("u_mon", int'(u_mon), u_m[0]);
`ifdef DELTA_LIAFN_OVERRUN_CNT_EN
        check("ovr_cnt", int'(ovr_cnt), ovr_m);
`endif
        @(posedge clk); #1;
        check("done_pulse_end", int'(done), 0);
        check("idle_after", int'(busy), 0);
    endtask

    initial begin
        int lat, wait_n;
        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_u_mon", int'(u_mon), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single event on neuron 0
        wr_cur(0, 60);
        model_sweep();
        check("m1_n", exp_q.size(), 1);
        check("m1_addr", exp_q[0].addr, 0);
        check("m1_mag", exp_q[0].mag, 60);
        check("m1_spike", exp_q[0].spike, 0);
        do_sweep(0, 0, 0, lat);
        check("t1_latency", lat, 6);
        check("t1_u_mon", int'(u_mon), 60);

        // Integrate then fire on neuron 1
        wr_cur(0, 0);
        wr_cur(1, 150);
        model_sweep();
        check("m2_n", exp_q.size(), 1);
        check("m2_ev", exp_q[0].addr * 1000 + exp_q[0].mag * 2 + exp_q[0].spike, 1300);
        do_sweep(0, 0, 0, lat);
        model_sweep();
        check("m3_n", exp_q.size(), 1);
        check("m3_ev", exp_q[0].addr * 1000 + exp_q[0].mag * 2 + exp_q[0].spike, 1301);
        check("m3_u1", u_m[1], 0);
        do_sweep(0, 0, 0, lat);

        // Saturated spike with 5-cycle stall and dropped ticks every cycle
        wr_cur(1, 0);
        wr_cur(2, 255);
        model_sweep();
        check("m4_n", exp_q.size(), 1);
        check("m4_ev", exp_q[0].addr * 1000 + exp_q[0].mag * 2 + exp_q[0].spike, 2001);
        do_sweep(0, 100, 5, lat);
        check("t4_latency", lat, 11);

        // Out-of-range current writes are ignored
        for (int a = N; a < 16; a++) wr_cur(a, 250);
        model_sweep();
        do_sweep(0, 0, 0, lat);

        // Randomized sweeps
        for (int it = 0; it < 25; it++) begin
            int nw, bp;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) wr_cur($urandom_range(0, 15), $urandom_range(0, 255));
            bp = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(20, 70);
            model_sweep();
            do_sweep(bp, 10, 0, lat);
        end

        // Long stall with a tick every cycle drives the overrun count to saturation
        wr_cur(2, 255);
        model_sweep();
        do_sweep(0, 100, 300, lat);

        // Reset in the middle of EMIT
        wr_cur(3, 120);
        ev_ready = 1'b0;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        wait_n = 0;
        while (!ev_valid && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("emit_reached", int'(ev_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ev_valid", int'(ev_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_u_mon", int'(u_mon), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ev_ready = 1'b1;
        @(posedge clk); #1;
        wr_cur(0, 60);
        model_sweep();
        do_sweep(0, 0, 0, lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_u_mon", int'(u_mon), 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
